// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-of-day / button front end and the alarm controller.
// The master drives time, alarm digits and buttons; the slave returns alarm time, buzzer and status.
interface alarm_ctrl_if;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       alarm_en;
  logic       set_alarm;
  logic [3:0] al_hour1;
  logic [3:0] al_hour0;
  logic [3:0] al_min1;
  logic [3:0] al_min0;
  logic       stop;
  logic       snooze;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic       buzz;
  logic       ringing;
  logic       snoozing;
  logic       set_err;

  modport master (
    output hour, minute, second, alarm_en, set_alarm,
    output al_hour1, al_hour0, al_min1, al_min0, stop, snooze,
    input  alarm_hour, alarm_minute, buzz, ringing, snoozing, set_err
  );

  modport slave (
    input  hour, minute, second, alarm_en, set_alarm,
    input  al_hour1, al_hour0, al_min1, al_min0, stop, snooze,
    output alarm_hour, alarm_minute, buzz, ringing, snoozing, set_err
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the alarm time from BCD-style digits, detects the match on the
// second rollover to :00 and runs the ring/snooze FSM that drives the buzzer square wave.
module alarm_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 50000
) (
  input  logic         clk,
  input  logic         rst,
  alarm_ctrl_if.slave  bus
);
  localparam int WAIT_LEN = SNOOZE_MINUTES * 60;
  localparam int RING_W   = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int WAIT_W   = (WAIT_LEN > 1) ? $clog2(WAIT_LEN) : 1;
  localparam int SNZ_W    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  state_t              r_state, w_state_next;
  logic [RING_W-1:0]   r_ring_cnt, w_ring_cnt_next;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_next;
  logic [SNZ_W-1:0]    r_snooze_cnt, w_snooze_cnt_next;
  logic [TONE_W-1:0]   r_tone_cnt, w_tone_cnt_next;
  logic                r_tone, w_tone_next;
  logic                r_buzz, r_set_err;
  logic [5:0]          r_alarm_hour, r_alarm_minute, r_sec_q;

  logic       w_sec_tick, w_match;
  logic       w_h_keep, w_m_keep, w_bad_digit, w_set_ok;
  logic [3:0] w_h1, w_h0, w_m1, w_m0;
  logic [6:0] w_hour7, w_min7;

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9) && (d != 4'hA);
  endfunction

  // Any change of the incoming second counts as a tick, including jumps from time setting.
  assign w_sec_tick = (bus.second != r_sec_q);
  assign w_match    = w_sec_tick && bus.alarm_en && (r_state == ST_IDLE) &&
                      (bus.hour == r_alarm_hour) && (bus.minute == r_alarm_minute) &&
                      (bus.second == 6'd0);

  // Field with both digits 4'hA is kept; a single 4'hA digit counts as zero.
  assign w_h_keep    = (bus.al_hour1 == 4'hA) && (bus.al_hour0 == 4'hA);
  assign w_m_keep    = (bus.al_min1 == 4'hA) && (bus.al_min0 == 4'hA);
  assign w_h1        = (bus.al_hour1 == 4'hA) ? 4'd0 : bus.al_hour1;
  assign w_h0        = (bus.al_hour0 == 4'hA) ? 4'd0 : bus.al_hour0;
  assign w_m1        = (bus.al_min1 == 4'hA) ? 4'd0 : bus.al_min1;
  assign w_m0        = (bus.al_min0 == 4'hA) ? 4'd0 : bus.al_min0;
  assign w_hour7     = 7'(w_h1) * 7'd10 + 7'(w_h0);
  assign w_min7      = 7'(w_m1) * 7'd10 + 7'(w_m0);
  assign w_bad_digit = digit_bad(bus.al_hour1) || digit_bad(bus.al_hour0) ||
                       digit_bad(bus.al_min1) || digit_bad(bus.al_min0);
  assign w_set_ok    = !w_bad_digit && (w_h_keep || (w_hour7 <= 7'd23)) &&
                       (w_m_keep || (w_min7 <= 7'd59));

  always_comb begin
    w_state_next      = r_state;
    w_ring_cnt_next   = r_ring_cnt;
    w_wait_cnt_next   = r_wait_cnt;
    w_snooze_cnt_next = r_snooze_cnt;
    w_tone_cnt_next   = r_tone_cnt;
    w_tone_next       = r_tone;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_state_next      = ST_RING;
          w_ring_cnt_next   = '0;
          w_snooze_cnt_next = '0;
          w_tone_cnt_next   = '0;
          w_tone_next       = 1'b0;
        end
      end
      ST_RING: begin
        if (r_tone_cnt == TONE_W'(TONE_DIV - 1)) begin
          w_tone_cnt_next = '0;
          w_tone_next     = ~r_tone;
        end else begin
          w_tone_cnt_next = r_tone_cnt + TONE_W'(1);
        end
        if (bus.stop) begin
          w_state_next = ST_IDLE;
        end else if (bus.snooze) begin
          // Once the snooze budget is spent, snooze behaves like stop.
          if (r_snooze_cnt < SNZ_W'(MAX_SNOOZE)) begin
            w_state_next      = ST_SNOOZE;
            w_snooze_cnt_next = r_snooze_cnt + SNZ_W'(1);
            w_wait_cnt_next   = '0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (w_sec_tick) begin
          if (r_ring_cnt == RING_W'(RING_SECONDS - 1)) w_state_next = ST_IDLE;
          else w_ring_cnt_next = r_ring_cnt + RING_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (bus.stop) begin
          w_state_next = ST_IDLE;
        end else if (w_sec_tick) begin
          if (r_wait_cnt == WAIT_W'(WAIT_LEN - 1)) begin
            w_state_next    = ST_RING;
            w_ring_cnt_next = '0;
            w_tone_cnt_next = '0;
            w_tone_next     = 1'b0;
          end else begin
            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (!bus.alarm_en) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ring_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_snooze_cnt   <= '0;
      r_tone_cnt     <= '0;
      r_tone         <= 1'b0;
      r_buzz         <= 1'b0;
      r_set_err      <= 1'b0;
      r_alarm_hour   <= '0;
      r_alarm_minute <= '0;
      r_sec_q        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ring_cnt   <= w_ring_cnt_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_snooze_cnt <= w_snooze_cnt_next;
      r_tone_cnt   <= w_tone_cnt_next;
      r_tone       <= w_tone_next;
      // Buzz follows the next tone/state so it drops on the same edge that leaves RING.
      r_buzz       <= w_tone_next && (w_state_next == ST_RING);
      r_sec_q      <= bus.second;
      r_set_err    <= bus.set_alarm && !w_set_ok;
      if (bus.set_alarm && w_set_ok) begin
        if (!w_h_keep) r_alarm_hour <= w_hour7[5:0];
        if (!w_m_keep) r_alarm_minute <= w_min7[5:0];
      end
    end
  end

  assign bus.alarm_hour   = r_alarm_hour;
  assign bus.alarm_minute = r_alarm_minute;
  assign bus.buzz         = r_buzz;
  assign bus.ringing      = (r_state == ST_RING);
  assign bus.snoozing     = (r_state == ST_SNOOZE);
  assign bus.set_err      = r_set_err;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: table of alarm-set vectors plus hand-written ring/snooze sequences.
module tb_alarm_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alarm_ctrl_if u_if ();

  alarm_ctrl #(
    .RING_SECONDS(3), .SNOOZE_MINUTES(1), .MAX_SNOOZE(1), .TONE_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h1, h0, m1, m0;
    logic [5:0] exp_hour, exp_min;
    logic       exp_err;
  } set_vec_t;

  set_vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    u_if.hour   = 6'(h);
    u_if.minute = 6'(m);
    u_if.second = 6'(s);
    tick();
  endtask

  task automatic trigger();
    set_time(7, 29, 59);
    set_time(7, 30, 0);
  endtask

  task automatic pulse_snooze();
    u_if.snooze = 1'b1;
    tick();
    u_if.snooze = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'h0, 4'h7, 4'h3, 4'h0, 6'd7,  6'd30, 1'b0};
    vecs[1] = '{4'h2, 4'h5, 4'h0, 4'h0, 6'd7,  6'd30, 1'b1};
    vecs[2] = '{4'hA, 4'hA, 4'h4, 4'h5, 6'd7,  6'd45, 1'b0};
    vecs[3] = '{4'h1, 4'hA, 4'hA, 4'hA, 6'd10, 6'd45, 1'b0};
    vecs[4] = '{4'h2, 4'h3, 4'h5, 4'h9, 6'd23, 6'd59, 1'b0};
    vecs[5] = '{4'h0, 4'h0, 4'h6, 4'h0, 6'd23, 6'd59, 1'b1};
    vecs[6] = '{4'hB, 4'h1, 4'h0, 4'h0, 6'd23, 6'd59, 1'b1};
    vecs[7] = '{4'hA, 4'hA, 4'hA, 4'hA, 6'd23, 6'd59, 1'b0};
    vecs[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 6'd0,  6'd0,  1'b0};
    vecs[9] = '{4'h0, 4'h7, 4'h3, 4'h0, 6'd7,  6'd30, 1'b0};

    u_if.hour = '0; u_if.minute = '0; u_if.second = '0;
    u_if.alarm_en = 1'b0; u_if.set_alarm = 1'b0;
    u_if.al_hour1 = '0; u_if.al_hour0 = '0; u_if.al_min1 = '0; u_if.al_min0 = '0;
    u_if.stop = 1'b0; u_if.snooze = 1'b0;

    tick(); tick();
    check("reset alarm_hour", int'(u_if.alarm_hour), 0);
    check("reset alarm_minute", int'(u_if.alarm_minute), 0);
    check("reset buzz", int'(u_if.buzz), 0);
    check("reset ringing", int'(u_if.ringing), 0);
    check("reset snoozing", int'(u_if.snoozing), 0);
    check("reset set_err", int'(u_if.set_err), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      u_if.al_hour1 = vecs[i].h1; u_if.al_hour0 = vecs[i].h0;
      u_if.al_min1  = vecs[i].m1; u_if.al_min0  = vecs[i].m0;
      u_if.set_alarm = 1'b1;
      tick();
      u_if.set_alarm = 1'b0;
      $display("set vec %0d digits %h%h:%h%h -> %0d:%0d err=%0d", i, vecs[i].h1, vecs[i].h0,
               vecs[i].m1, vecs[i].m0, u_if.alarm_hour, u_if.alarm_minute, u_if.set_err);
      check($sformatf("set%0d hour", i), int'(u_if.alarm_hour), int'(vecs[i].exp_hour));
      check($sformatf("set%0d minute", i), int'(u_if.alarm_minute), int'(vecs[i].exp_min));
      check($sformatf("set%0d err", i), int'(u_if.set_err), int'(vecs[i].exp_err));
      tick();
      check($sformatf("set%0d err clears", i), int'(u_if.set_err), 0);
    end

    // Alarm 07:30 armed: match on rollover to 07:30:00, then tone toggles every 4 clocks.
    u_if.alarm_en = 1'b1;
    set_time(7, 29, 59);
    check("pre-match ringing", int'(u_if.ringing), 0);
    set_time(7, 30, 0);
    $display("match: ringing=%0d buzz=%0d", u_if.ringing, u_if.buzz);
    check("match ringing", int'(u_if.ringing), 1);
    check("entry buzz", int'(u_if.buzz), 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      $display("tone clk %0d buzz=%0d", k, u_if.buzz);
      check($sformatf("buzz clk%0d", k), int'(u_if.buzz), ((k / 4) % 2));
    end

    // Auto-off on the third second change.
    set_time(7, 30, 1);
    check("auto-off tick1", int'(u_if.ringing), 1);
    set_time(7, 30, 2);
    check("auto-off tick2", int'(u_if.ringing), 1);
    set_time(7, 30, 3);
    $display("auto-off: ringing=%0d buzz=%0d", u_if.ringing, u_if.buzz);
    check("auto-off ringing", int'(u_if.ringing), 0);
    check("auto-off buzz", int'(u_if.buzz), 0);
    set_time(7, 30, 4);
    check("no retrigger", int'(u_if.ringing), 0);

    // Snooze, re-ring after 60 ticks, second snooze exhausts budget.
    trigger();
    check("snz trigger", int'(u_if.ringing), 1);
    pulse_snooze();
    check("snooze snoozing", int'(u_if.snoozing), 1);
    check("snooze ringing", int'(u_if.ringing), 0);
    check("snooze buzz", int'(u_if.buzz), 0);
    for (int i = 1; i <= 60; i++) begin
      set_time(7, (i == 60) ? 31 : 30, i % 60);
      if (i == 59) check("snooze tick59", int'(u_if.snoozing), 1);
    end
    $display("re-ring: ringing=%0d snoozing=%0d", u_if.ringing, u_if.snoozing);
    check("re-ring ringing", int'(u_if.ringing), 1);
    check("re-ring snoozing", int'(u_if.snoozing), 0);
    pulse_snooze();
    check("snooze max ringing", int'(u_if.ringing), 0);
    check("snooze max snoozing", int'(u_if.snoozing), 0);

    // Stop and snooze together: stop wins.
    trigger();
    check("ss trigger", int'(u_if.ringing), 1);
    u_if.stop = 1'b1; u_if.snooze = 1'b1;
    tick();
    u_if.stop = 1'b0; u_if.snooze = 1'b0;
    $display("stop+snooze: ringing=%0d snoozing=%0d", u_if.ringing, u_if.snoozing);
    check("stop+snooze ringing", int'(u_if.ringing), 0);
    check("stop+snooze snoozing", int'(u_if.snoozing), 0);

    // Stop during snooze.
    trigger();
    pulse_snooze();
    check("snz-stop snoozing", int'(u_if.snoozing), 1);
    u_if.stop = 1'b1;
    tick();
    u_if.stop = 1'b0;
    check("snz-stop idle", int'(u_if.snoozing), 0);

    // Disarm while ringing, and no match while disarmed.
    trigger();
    check("dis trigger", int'(u_if.ringing), 1);
    u_if.alarm_en = 1'b0;
    tick();
    check("disarm ringing", int'(u_if.ringing), 0);
    trigger();
    check("disarmed no match", int'(u_if.ringing), 0);
    u_if.alarm_en = 1'b1;

    // Asynchronous reset while snoozing, checked between clock edges.
    trigger();
    pulse_snooze();
    check("pre-rst snoozing", int'(u_if.snoozing), 1);
    check("pre-rst alarm_hour", int'(u_if.alarm_hour), 7);
    #3;
    rst = 1'b1;
    #1;
    $display("async rst: snoozing=%0d hour=%0d minute=%0d", u_if.snoozing, u_if.alarm_hour,
             u_if.alarm_minute);
    check("rst snoozing", int'(u_if.snoozing), 0);
    check("rst ringing", int'(u_if.ringing), 0);
    check("rst buzz", int'(u_if.buzz), 0);
    check("rst alarm_hour", int'(u_if.alarm_hour), 0);
    check("rst alarm_minute", int'(u_if.alarm_minute), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller directly downstream of the time-of-day counter.
- Consumes the binary hour/minute/second values, stores a user-set alarm time and detects a match.
- Runs the ring/snooze state machine and drives a buzzer tone plus status flags for the display stage.

Parameters:
RING_SECONDS, 60, seconds a ring lasts before auto-off
SNOOZE_MINUTES, 5, snooze delay before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze press acts as stop
TONE_DIV, 50000, clk cycles per buzzer half-period

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
hour  in  6  current hour, binary 0-23
minute  in  6  current minute, binary 0-59
second  in  6  current second, binary 0-59
alarm_en  in  1  level; alarm armed when high
set_alarm  in  1  one-clk pulse; load alarm digits
al_hour1  in  4  alarm hour tens digit; 4'hA = keep field
al_hour0  in  4  alarm hour units digit; 4'hA = keep field
al_min1  in  4  alarm minute tens digit; 4'hA = keep field
al_min0  in  4  alarm minute units digit; 4'hA = keep field
stop  in  1  one-clk pulse, debounced
snooze  in  1  one-clk pulse, debounced
alarm_hour  out  6  stored alarm hour
alarm_minute  out  6  stored alarm minute
buzz  out  1  buzzer square wave
ringing  out  1  state==RING
snoozing  out  1  state==SNOOZE
set_err  out  1  one-clk pulse on rejected set_alarm

Behaviour:
- Reset values: alarm_hour=0, alarm_minute=0, buzz=0, ringing=0, snoozing=0, set_err=0, state=IDLE, all counters 0, sec_q=0.
- Second tick:
  - sec_q registers second every clk.
  - sec_tick = (second != sec_q), combinational.
  - Any change of second counts as one tick, including jumps caused by time setting.
- Alarm set:
  - Applies on a clk where set_alarm=1.
  - Hour field: if both hour digits are 4'hA, keep the stored hour. If exactly one hour digit is 4'hA, treat it as 0.
  - Minute field follows the same rule.
  - New hour = h1*10+h0; new minute = m1*10+m0. Compute at 7-bit width, then truncate to 6 bits.
  - Reject the whole set if any non-A digit is >9, new hour >23, or new minute >59. On reject, nothing changes and set_err pulses the next cycle.
  - Accepted values are visible on alarm_hour/alarm_minute the next cycle.
  - A set during RING or SNOOZE updates the registers but does not alter the current ring or snooze.
- Match: sec_tick & alarm_en & state==IDLE & hour==alarm_hour & minute==alarm_minute & second==0.
- FSM (registered; transitions at the clk edge after the qualifying cycle):
  - IDLE -> RING on match. ring_cnt=0, snooze_cnt=0, tone counter=0, tone=0.
  - RING:
    - ring_cnt increments per sec_tick.
    - stop -> IDLE.
    - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE. snooze_cnt++, wait_cnt=0.
    - snooze with snooze_cnt==MAX_SNOOZE -> IDLE.
    - ring_cnt reaching RING_SECONDS-1 on a sec_tick -> IDLE (auto-off).
  - SNOOZE:
    - wait_cnt increments per sec_tick.
    - On reaching SNOOZE_MINUTES*60-1 on a sec_tick -> RING. ring_cnt=0, tone reset, snooze_cnt kept.
    - stop -> IDLE.
    - snooze is ignored.
  - Any state: alarm_en=0 -> IDLE on the next edge. This has priority over all other transitions.
- Priority within one cycle: alarm_en low > stop > snooze > timeout.
- Buzzer and status outputs:
  - Tone counter runs only in RING. tone toggles when the counter reaches TONE_DIV-1, then the counter clears.
  - buzz = tone & ringing, registered.
  - buzz=0 in every other state.
- No re-trigger in the same minute after stop: match requires second==0, so the alarm fires again only 24 h later.
- rst mid-ring or mid-snooze: immediate IDLE, buzz=0, stored alarm time cleared to 00:00.

Test Plan:
(bench params: RING_SECONDS=3, SNOOZE_MINUTES=1, MAX_SNOOZE=1, TONE_DIV=4)
- Set digits 0,7,3,0 pulse -> alarm_hour=7, alarm_minute=30 next cycle. Set 2,5,0,0 -> set_err pulse, alarm stays 07:30. Set A,A,4,5 -> 07:45.
- alarm_en=1, alarm 07:30, drive time 07:29:59 -> 07:30:00 -> ringing=1 on the next edge; buzz toggles every 4 clk, first rise 4 clk after entry.
- Ringing, no input, 3 second changes -> ringing=0, buzz=0 after the third tick.
- Ringing, snooze pulse -> snoozing=1. After 60 second ticks -> ringing=1. Second snooze (cnt==MAX) -> IDLE.
- Ringing, stop and snooze in the same cycle -> IDLE, snoozing stays 0. Ringing, alarm_en=0 -> IDLE next edge.
- Assert rst while snoozing -> all outputs 0 and alarm_hour/alarm_minute=0 immediately, without waiting for a clk edge.
